// File: rtl/sipo.sv
// Serial-in/parallel-out deserializer with word-boundary realignment and a valid/ready output port.
// Optional macro SIPO_OVERRUN_DETECT_EN: drop words that arrive while the output is stalled and flag overrun_o.
module sipo #(
    parameter int    DATA_WIDTH   = 8,
    parameter string DO_MSB_FIRST = "FALSE"
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic                  enable_i,
    input  logic                  align_i,
    input  logic                  data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH);
    localparam bit                MSB_FIRST = (DO_MSB_FIRST == "TRUE");
    localparam logic [CNT_W-1:0]  LAST_POS  = CNT_W'(DATA_WIDTH - 32'sd1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   shift_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_s;
    logic [CNT_W-1:0]        pos_s;
    logic                    take_s;
    logic                    complete_s;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   data_s;
    logic                    valid_r;
    logic                    valid_s;
    logic                    stall_s;

    // Word bit that receives serial position pos, mirroring the serializer's bit order.
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] pos);
        if (MSB_FIRST) begin
            return LAST_POS - pos;
        end else begin
            return pos;
        end
    endfunction

    // Next-state, shift-register and bit-counter logic.
    always_comb begin
        next_state_s = state_r;
        shift_s      = shift_r;
        cnt_s        = cnt_r;
        pos_s        = '0;
        take_s       = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable_i && align_i) begin
                    take_s       = 1'b1;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (enable_i) begin
                    take_s = 1'b1;
                    pos_s  = align_i ? '0 : cnt_r;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        if (take_s) begin
            // Position 0 starts a fresh word, so any partial word is discarded here.
            if (pos_s == '0) begin
                shift_s = '0;
            end else begin
                shift_s = shift_r;
            end
            shift_s[bit_index(pos_s)] = data_i;
            if (pos_s == LAST_POS) begin
                complete_s = 1'b1;
                cnt_s      = '0;
            end else begin
                cnt_s = pos_s + CNT_W'(32'd1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    assign stall_s = valid_r && !ready_i;

    // Output-port update: load on completion, clear on a transfer without a new word.
    always_comb begin
        data_s  = data_r;
        valid_s = valid_r;
        if (complete_s) begin
            if (!stall_s) begin
                data_s  = shift_s;
                valid_s = 1'b1;
            end else begin
`ifdef SIPO_OVERRUN_DETECT_EN
                data_s  = data_r;
                valid_s = 1'b1;
`else
                data_s  = shift_s;
                valid_s = 1'b1;
`endif
            end
        end else if (valid_r && ready_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state_r <= IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            shift_r <= shift_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            valid_r <= valid_s;
        end
    end

`ifdef SIPO_OVERRUN_DETECT_EN
    logic overrun_r;

    // Sticky overrun flag: set when a completed word is dropped, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            overrun_r <= 1'b0;
        end else if (complete_s && stall_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign overrun_o = overrun_r;
`else
    assign overrun_o = 1'b0;
`endif

    assign data_o  = data_r;
    assign valid_o = valid_r;

endmodule
